// File: rtl/async_up_counter.sv
// Ripple up-counter: a chain of toggle stages. Stage 0 runs on clk, and each
// later stage runs on the falling edge of the stage below it. rst clears every stage.
module async_up_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  // stage_clk[i] is the clock of stage i. Stage i toggles on the rising edge
  // of ~count[i-1], which is the 1 -> 0 fall of the bit below.
  logic [WIDTH-1:0] stage_clk;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic stage_q;
    logic stage_d;

    if (i == 0) begin : g_lsb
      assign stage_clk[i] = clk;
    end else begin : g_upper
      assign stage_clk[i] = ~count[i-1];
    end

    always_comb begin
      stage_d = ~stage_q;
    end

    always_ff @(posedge stage_clk[i] or posedge rst) begin
      if (rst) begin
        stage_q <= 1'b0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign count[i] = stage_q;
  end

endmodule

// File: tb/tb_async_up_counter.sv
// Checks the ripple counter against an integer model. The bench runs a
// WIDTH=3 counter and a WIDTH=4 counter together on the same clk and rst.
module tb_async_up_counter;

  logic       clk;
  logic       rst;
  logic [2:0] count3;
  logic [3:0] count4;

  int vectors;
  int miscompares;
  int m3;
  int m4;

  async_up_counter #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .count(count3));
  async_up_counter #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .count(count4));

  // clock/reset: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Returns 1 if every bit i>=1 that changed did so only because bit i-1 fell from 1 to 0.
  function automatic logic toggle_rule_ok(input logic [31:0] prev, input logic [31:0] nxt, input int w);
    logic ok;
    ok = 1'b1;
    for (int i = 1; i < w; i++) begin
      if (prev[i] != nxt[i] && !(prev[i-1] == 1'b1 && nxt[i-1] == 1'b0)) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic check_both(input string tag);
    check({tag, "_w3"}, {29'd0, count3}, m3 % 8);
    check({tag, "_w4"}, {28'd0, count4}, m4 % 16);
  endtask

  // One rising edge. The model counts only when rst is low.
  task automatic do_edge(input string tag);
    logic [31:0] p3;
    logic [31:0] p4;
    p3 = {29'd0, count3};
    p4 = {28'd0, count4};
    @(posedge clk);
    #1;
    if (!rst) begin
      m3 = (m3 + 1) % 8;
      m4 = (m4 + 1) % 16;
    end
    check_both(tag);
    if (!rst) begin
      check({tag, "_rule_w3"}, {31'd0, toggle_rule_ok(p3, {29'd0, count3}, 3)}, 32'd1);
      check({tag, "_rule_w4"}, {31'd0, toggle_rule_ok(p4, {28'd0, count4}, 4)}, 32'd1);
    end
  endtask

  task automatic reset_pulse(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    m3 = 0;
    m4 = 0;
    check_both(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m3          = 0;
    m4          = 0;
    rst         = 1'b1;

    // Reset held across the t=5 edge
    #1;
    check_both("reset_t1");
    @(posedge clk);
    #1;
    check_both("reset_edge5");
    #4;
    rst = 1'b0;

    // Release at t=10: edges at 15, 25, 35 give 1, 2, 3
    do_edge("release_1");
    do_edge("release_2");
    do_edge("release_3");
    check({"release_const"}, {29'd0, count3}, 32'd3);

    // Full sequence: W3 wraps twice, W4 reaches 1111 and then wraps on edge 16
    reset_pulse("pre_wrap");
    for (int i = 0; i < 16; i++) begin
      do_edge("wrap");
      if (i == 14) check("w4_all_ones", {28'd0, count4}, 32'd15);
    end
    check("w4_wrap_zero", {28'd0, count4}, 32'd0);

    // Asynchronous reset mid-count at 101, between edges
    reset_pulse("pre_mid");
    repeat (5) do_edge("to_five");
    check("at_five", {29'd0, count3}, 32'd5);
    #2;
    rst = 1'b1;
    #1;
    m3 = 0;
    m4 = 0;
    check_both("async_clear");
    repeat (3) do_edge("hold_in_reset");
    @(negedge clk);
    rst = 1'b0;
    do_edge("first_after_release");
    check("first_is_one", {29'd0, count3}, 32'd1);

    // Reset in the same timestep as the 011 -> 100 ripple
    reset_pulse("pre_ripple");
    repeat (3) do_edge("to_three");
    @(posedge clk);
    rst = 1'b1;
    #1;
    m3 = 0;
    m4 = 0;
    check_both("ripple_abort");
    @(negedge clk);
    rst = 1'b0;

    // Random mix of counting edges and reset pulses
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) reset_pulse("rand_reset");
      else do_edge("rand_edge");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
